instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch.sv | 119 +++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-unit definitions: FSM encoding, reset PC, instruction field positions, buffer depth.
// Buffer depth depends on the FETCH_PREFETCH_EN macro (defined: 2 entries, undefined: 1 entry).
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

`ifdef FETCH_PREFETCH_EN
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, instr} pairs; supports push/pop/flush and
// a simultaneous push and pop when full.
module fetch_fifo #(
  parameter int DEPTH = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads to instruction memory, buffers responses,
// and handles redirects. FETCH_PREFETCH_EN selects a 2-entry prefetch buffer.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic [5:0]         op,
  output logic [5:0]         funct
);

  localparam int DEPTH = FETCH_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q;
  logic          outst_q, outst_d;
  logic          drop_q, drop_d;

  logic          grant, rsp_live, push, pop;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   cnt_after;
  logic          fifo_full, fifo_empty;
  logic [63:0]   fifo_rdata;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // A new request needs no response in flight and a free slot for it
  assign imem_req  = rst_n && (state_q == ST_REQ) && !redirect && !outst_q && !fifo_full;
  assign imem_addr = fetch_pc_q[IMEM_AW-1:0];
  assign grant     = imem_req && imem_gnt;
  assign rsp_live  = imem_rvalid && outst_q && !drop_q;
  assign push      = rsp_live && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;
  assign cnt_after = ({1'b0, fifo_count} + (CW+1)'(1)) - (CW+1)'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d    = 1'b1;
    end
    if (imem_rvalid && outst_q) begin
      outst_d = 1'b0;
      drop_d  = 1'b0;
    end
    unique case (state_q)
      ST_REQ:  if (grant) state_d = ST_WAIT;
      ST_WAIT: if (rsp_live) state_d = (cnt_after < (CW+1)'(DEPTH)) ? ST_REQ : ST_HOLD;
      ST_HOLD: if (pop) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
    // A response still in flight at redirect time belongs to the old stream
    if (redirect) begin
      state_d    = ST_REQ;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      outst_d    = outst_q && !imem_rvalid;
      drop_d     = outst_q && !imem_rvalid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      if (grant) req_pc_q <= fetch_pc_q;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({req_pc_q, imem_rdata}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_pc    = fifo_rdata[63:32];
  assign instr       = fifo_rdata[31:0];
  assign op          = instr[OP_MSB:OP_LSB];
  assign funct       = instr[FUNCT_MSB:FUNCT_LSB];

endmodule
